// File: rtl/sw_hw_mailbox_ctrl.sv
// Hardware side of the software-to-hardware mailbox.
// Software posts NUM_WORDS words with a 4-phase handshake on to_hw_sig/to_sw_sig.
// The words are captured one per cycle into a shadow bank. The shadow bank is copied
// to the active bank only on a frame boundary, so consumers never see a torn frame.
module sw_hw_mailbox_ctrl #(
    parameter int unsigned NUM_WORDS      = 10,
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_WORDS*WORD_W-1:0] port_in,
    input  logic [1:0]                  to_hw_sig,
    output logic [1:0]                  to_sw_sig,
    input  logic                        frame_start,
    output logic [NUM_WORDS*WORD_W-1:0] active_words,
    output logic                        commit_pulse,
    output logic                        frame_valid,
    output logic                        timeout_err
);

    localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCapture = 3'd1;
    localparam logic [2:0] StAck     = 3'd2;
    localparam logic [2:0] StBusy    = 3'd3;
    localparam logic [2:0] StErr     = 3'd4;

    localparam logic [1:0] SigIdle  = 2'b00;
    localparam logic [1:0] SigPost  = 2'b01;
    localparam logic [1:0] SigAbort = 2'b11;

    logic [2:0]                  state_q, state_d;
    logic [IdxW-1:0]             word_idx_q, word_idx_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [NUM_WORDS*WORD_W-1:0] shadow_q, shadow_d;
    logic [NUM_WORDS*WORD_W-1:0] active_q, active_d;
    logic                        pending_q, pending_d;
    logic                        commit_pulse_q, commit_pulse_d;
    logic                        frame_valid_q, frame_valid_d;
    logic                        timeout_err_q, timeout_err_d;
    logic                        commit;

    // Next-state logic: handshake FSM, word capture, timeout and frame-boundary commit
    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        pending_d     = pending_q;
        frame_valid_d = frame_valid_q;
        timeout_err_d = timeout_err_q;

        // Never commit while the shadow is being written; wait for the next frame instead.
        commit         = frame_start && pending_q && (state_q != StCapture);
        commit_pulse_d = commit;
        if (commit) begin
            active_d      = shadow_q;
            pending_d     = 1'b0;
            frame_valid_d = 1'b1;
        end

        if ((to_hw_sig == SigAbort) && (state_q != StErr)) begin
            // Abort drops any partial capture; pending stays as it was.
            state_d    = StIdle;
            word_idx_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (to_hw_sig == SigPost) begin
                        if (pending_q) begin
                            state_d = StBusy;
                        end else begin
                            state_d    = StCapture;
                            word_idx_d = '0;
                        end
                    end
                end
                StBusy: begin
                    // Uses registered pending, so CAPTURE follows a commit by one cycle.
                    if (!pending_q && (to_hw_sig == SigPost)) begin
                        state_d    = StCapture;
                        word_idx_d = '0;
                    end else if (to_hw_sig == SigIdle) begin
                        state_d = StIdle;
                    end
                end
                StCapture: begin
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        if (word_idx_q == IdxW'(k)) begin
                            shadow_d[k*WORD_W +: WORD_W] = port_in[k*WORD_W +: WORD_W];
                        end
                    end
                    if (word_idx_q == LastIdx) begin
                        pending_d  = 1'b1;
                        state_d    = StAck;
                        cnt_d      = '0;
                        word_idx_d = '0;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
                StAck: begin
                    if (to_hw_sig == SigIdle) begin
                        state_d = StIdle;
                    end else begin
                        // Saturating count of cycles software has held the post.
                        if (cnt_q != CntMax) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (cnt_d == CntMax) begin
                            state_d       = StErr;
                            timeout_err_d = 1'b1;
                        end
                    end
                end
                StErr: begin
                    if (to_hw_sig == SigIdle) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= StIdle;
            word_idx_q     <= '0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            active_q       <= '0;
            pending_q      <= 1'b0;
            commit_pulse_q <= 1'b0;
            frame_valid_q  <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_idx_q     <= word_idx_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            commit_pulse_q <= commit_pulse_d;
            frame_valid_q  <= frame_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    // Handshake response decoded purely from the state register
    always_comb begin
        case (state_q)
            StAck:   to_sw_sig = 2'b01;
            StBusy:  to_sw_sig = 2'b10;
            StErr:   to_sw_sig = 2'b11;
            default: to_sw_sig = 2'b00;
        endcase
    end

    assign active_words = active_q;
    assign commit_pulse = commit_pulse_q;
    assign frame_valid  = frame_valid_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_sw_hw_mailbox_ctrl.sv
// Directed bench for sw_hw_mailbox_ctrl: handshake timing, busy/commit ordering,
// abort, timeout, frame_start during capture and asynchronous reset.
module tb_sw_hw_mailbox_ctrl;

    localparam int unsigned NW = 10;
    localparam int unsigned WW = 32;
    localparam int unsigned BW = NW * WW;

    logic          Clk;
    logic          Reset;
    logic [BW-1:0] port_in;
    logic [1:0]    to_hw_sig;
    logic [1:0]    to_sw_sig;
    logic          frame_start;
    logic [BW-1:0] active_words;
    logic          commit_pulse;
    logic          frame_valid;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    sw_hw_mailbox_ctrl #(
        .NUM_WORDS      (NW),
        .WORD_W         (WW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .port_in      (port_in),
        .to_hw_sig    (to_hw_sig),
        .to_sw_sig    (to_sw_sig),
        .frame_start  (frame_start),
        .active_words (active_words),
        .commit_pulse (commit_pulse),
        .frame_valid  (frame_valid),
        .timeout_err  (timeout_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [BW-1:0] words(input logic [31:0] base);
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < NW; k++) v[k*WW +: WW] = base + 32'(k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    initial begin
        Reset       = 1'b1;
        to_hw_sig   = 2'b00;
        frame_start = 1'b0;
        port_in     = '0;
        tick(2);
        chk("rst_sw", BW'(to_sw_sig), BW'(2'b00));
        chk("rst_active", active_words, '0);
        chk("rst_commit", BW'(commit_pulse), '0);
        chk("rst_fvalid", BW'(frame_valid), '0);
        chk("rst_terr", BW'(timeout_err), '0);
        Reset = 1'b0;
        tick(1);

        // 1: basic post, ack on the 11th edge, release, commit
        port_in   = words(32'h100);
        to_hw_sig = 2'b01;
        tick(10);
        chk("t1_no_ack_yet", BW'(to_sw_sig), BW'(2'b00));
        tick(1);
        chk("t1_ack", BW'(to_sw_sig), BW'(2'b01));
        to_hw_sig = 2'b00;
        port_in   = words(32'hDEAD0000);
        tick(1);
        chk("t1_release", BW'(to_sw_sig), BW'(2'b00));
        chk("t1_no_commit_yet", active_words, '0);
        pulse_frame();
        chk("t1_active", active_words, words(32'h100));
        chk("t1_commit", BW'(commit_pulse), BW'(1'b1));
        chk("t1_fvalid", BW'(frame_valid), BW'(1'b1));
        tick(1);
        chk("t1_commit_1cyc", BW'(commit_pulse), '0);

        // 2: post A, post B while A pending -> busy; commit A then capture B
        port_in   = words(32'h200);
        to_hw_sig = 2'b01;
        tick(11);
        chk("t2_ackA", BW'(to_sw_sig), BW'(2'b01));
        to_hw_sig = 2'b00;
        tick(1);
        port_in   = words(32'h300);
        to_hw_sig = 2'b01;
        tick(1);
        chk("t2_busy", BW'(to_sw_sig), BW'(2'b10));
        tick(1);
        chk("t2_busy_hold", BW'(to_sw_sig), BW'(2'b10));
        pulse_frame();
        chk("t2_activeA", active_words, words(32'h200));
        chk("t2_commitA", BW'(commit_pulse), BW'(1'b1));
        chk("t2_busy_on_commit", BW'(to_sw_sig), BW'(2'b10));
        tick(1);
        chk("t2_capture", BW'(to_sw_sig), BW'(2'b00));
        tick(9);
        chk("t2_no_ackB_yet", BW'(to_sw_sig), BW'(2'b00));
        tick(1);
        chk("t2_ackB", BW'(to_sw_sig), BW'(2'b01));
        to_hw_sig = 2'b00;
        tick(1);
        pulse_frame();
        chk("t2_activeB", active_words, words(32'h300));
        chk("t2_commitB", BW'(commit_pulse), BW'(1'b1));
        tick(1);

        // 3: abort on capture cycle 4 -> nothing pending, no commit
        port_in   = words(32'h400);
        to_hw_sig = 2'b01;
        tick(4);
        to_hw_sig = 2'b11;
        tick(1);
        chk("t3_abort_idle", BW'(to_sw_sig), BW'(2'b00));
        to_hw_sig = 2'b00;
        tick(1);
        pulse_frame();
        chk("t3_no_commit", BW'(commit_pulse), '0);
        chk("t3_active_kept", active_words, words(32'h300));
        tick(1);

        // 5: frame_start on the final capture cycle is ignored
        port_in   = words(32'h500);
        to_hw_sig = 2'b01;
        tick(10);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("t5_ack", BW'(to_sw_sig), BW'(2'b01));
        chk("t5_no_commit", BW'(commit_pulse), '0);
        chk("t5_active_kept", active_words, words(32'h300));
        to_hw_sig = 2'b00;
        tick(1);
        pulse_frame();
        chk("t5_commit", BW'(commit_pulse), BW'(1'b1));
        chk("t5_active", active_words, words(32'h500));
        tick(1);

        // 4: hold post through ACK -> error after 8 cycles, sticky flag
        port_in   = words(32'h600);
        to_hw_sig = 2'b01;
        tick(11);
        chk("t4_ack", BW'(to_sw_sig), BW'(2'b01));
        tick(7);
        chk("t4_ack_cnt7", BW'(to_sw_sig), BW'(2'b01));
        chk("t4_terr_clear", BW'(timeout_err), '0);
        tick(1);
        chk("t4_err", BW'(to_sw_sig), BW'(2'b11));
        chk("t4_terr_set", BW'(timeout_err), BW'(1'b1));
        to_hw_sig = 2'b00;
        tick(1);
        chk("t4_idle", BW'(to_sw_sig), BW'(2'b00));
        chk("t4_terr_sticky", BW'(timeout_err), BW'(1'b1));
        pulse_frame();
        chk("t4_active", active_words, words(32'h600));
        tick(1);

        // 6: asynchronous reset mid-capture, then a fresh post
        port_in   = words(32'h700);
        to_hw_sig = 2'b01;
        tick(4);
        #3;
        Reset = 1'b1;
        #1;
        chk("t6_rst_sw", BW'(to_sw_sig), '0);
        chk("t6_rst_active", active_words, '0);
        chk("t6_rst_fvalid", BW'(frame_valid), '0);
        chk("t6_rst_terr", BW'(timeout_err), '0);
        to_hw_sig = 2'b00;
        tick(1);
        Reset = 1'b0;
        tick(1);
        port_in   = words(32'h800);
        to_hw_sig = 2'b01;
        tick(10);
        chk("t6_no_ack_yet", BW'(to_sw_sig), BW'(2'b00));
        tick(1);
        chk("t6_ack", BW'(to_sw_sig), BW'(2'b01));
        to_hw_sig = 2'b00;
        tick(1);
        pulse_frame();
        chk("t6_active", active_words, words(32'h800));
        chk("t6_commit", BW'(commit_pulse), BW'(1'b1));
        chk("t6_fvalid", BW'(frame_valid), BW'(1'b1));
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
